// File: rtl/mac_stream_tx_if.sv
// Buffer-fill, MAC-stream and result-handoff signals of mac_stream_tx.
// master = environment (writer, MAC, consumer); slave = mac_stream_tx.
interface mac_stream_tx_if #(
  parameter int A_W = 8,
  parameter int F_W = 20
);
  logic           wr_en;
  logic [A_W-1:0] wr_data;
  logic           wr_ready;
  logic [3:0]     count;
  logic           start;
  logic [A_W-1:0] a;
  logic           valid_in;
  logic [F_W-1:0] f;
  logic           valid_out;
  logic [F_W-1:0] result;
  logic           result_valid;
  logic           result_ack;
  logic           err;
  logic           busy;

  modport master (
    output wr_en, wr_data, start, f, valid_out, result_ack,
    input  wr_ready, count, a, valid_in, result, result_valid, err, busy
  );

  modport slave (
    input  wr_en, wr_data, start, f, valid_out, result_ack,
    output wr_ready, count, a, valid_in, result, result_valid, err, busy
  );
endinterface

// File: rtl/mac_stream_tx.sv
// Buffers samples, streams them to a MAC one per cycle starting the cycle after start, then captures the final sum.
// Writes are refused (wr_ready=0) while streaming/draining or when full; result is held until result_ack.
module mac_stream_tx #(
  parameter int DEPTH = 8,
  parameter int A_W   = 8,
  parameter int F_W   = 20,
  parameter int TMO   = 15
) (
  input logic             clk,
  input logic             reset,
  mac_stream_tx_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TMO + 1);

  state_t         state_q, state_d;
  logic [A_W-1:0] mem_q [DEPTH];
  logic [A_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]     count_q, count_d;
  logic [3:0]     sent_q, sent_d;
  logic [3:0]     rcvd_q, rcvd_d;
  logic [TW-1:0]  idle_q, idle_d;
  logic [F_W-1:0] result_q, result_d;
  logic           err_q, err_d;
  logic           wr_rdy;
  logic           push;
  logic           pop;
  logic           vo_cnt;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    sent_d   = sent_q;
    idle_d   = idle_q;
    result_d = result_q;
    err_d    = err_q;

    // Gating with reset keeps wr_ready low for the whole reset pulse.
    wr_rdy = reset && ((state_q == IDLE) || (state_q == DONE)) && (count_q < 4'(DEPTH));
    push   = bus.wr_en && wr_rdy;
    pop    = (state_q == SEND);
    vo_cnt = bus.valid_out && ((state_q == SEND) || (state_q == DRAIN));
    rcvd_d = rcvd_q + {3'b000, vo_cnt};

    if (push) begin
      mem_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d        = wrap_inc(wr_ptr_q);
      count_d         = count_q + 4'd1;
    end
    if (pop) begin
      rd_ptr_d = wrap_inc(rd_ptr_q);
      count_d  = count_q - 4'd1;
      sent_d   = sent_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        idle_d = '0;
        if (bus.start && (count_q != 4'd0)) state_d = SEND;
      end
      SEND: begin
        idle_d = '0;
        if (count_q == 4'd1) state_d = DRAIN;
      end
      DRAIN: begin
        // Completion is tested first, so a last response already seen in SEND finishes here.
        if (rcvd_d == sent_q) begin
          result_d = bus.f;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (bus.valid_out) begin
          idle_d = '0;
        end else if (idle_q == TW'(TMO - 1)) begin
          result_d = bus.f;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.result_ack) begin
          sent_d  = '0;
          rcvd_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      rcvd_q   <= '0;
      idle_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      rcvd_q   <= rcvd_d;
      idle_q   <= idle_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.wr_ready     = wr_rdy;
  assign bus.count        = count_q;
  assign bus.valid_in     = (state_q == SEND);
  assign bus.a            = (state_q == SEND) ? mem_q[rd_ptr_q] : '0;
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == DONE);
  assign bus.err          = err_q && (state_q == DONE);
  assign bus.busy         = (state_q == SEND) || (state_q == DRAIN);
endmodule

// File: tb/tb_mac_stream_tx.sv
// Bench for mac_stream_tx: queue-based reference model checked every cycle plus directed literal checks.
module tb_mac_stream_tx;
  localparam int DEPTH = 8;
  localparam int A_W   = 8;
  localparam int F_W   = 20;
  localparam int TMO   = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mac_stream_tx_if #(.A_W(A_W), .F_W(F_W)) bus ();

  mac_stream_tx #(.DEPTH(DEPTH), .A_W(A_W), .F_W(F_W), .TMO(TMO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // Reference model: what is buffered, what is being streamed, what the consumer should see.
  int             mq[$];
  bit             streaming, waiting, holding, m_err;
  int             n_sent, n_resp, silent;
  logic [F_W-1:0] m_result;

  int rec_a[$];
  int rec_cyc[$];

  int mac_epoch = 0;
  int resp_cap  = -1;

  // MAC stand-in: answers each sample one cycle later with the running sum of squares.
  initial begin : mac_emu
    int             seen;
    int             given;
    bit             pend;
    logic [F_W-1:0] sum, sq;
    seen = 0; given = 0; pend = 1'b0; sum = '0; sq = '0;
    bus.valid_out = 1'b0;
    bus.f         = '0;
    forever begin
      @(negedge clk);
      if (mac_epoch != seen) begin
        seen = mac_epoch; sum = '0; given = 0; pend = 1'b0;
      end
      bus.valid_out = 1'b0;
      if (pend && (resp_cap < 0 || given < resp_cap)) begin
        sum = sum + sq;
        bus.f = sum;
        bus.valid_out = 1'b1;
        given++;
      end
      pend = bus.valid_in;
      sq   = F_W'(bus.a) * F_W'(bus.a);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @cyc %0d: actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    streaming = 0; waiting = 0; holding = 0; m_err = 0;
    n_sent = 0; n_resp = 0; silent = 0; m_result = '0;
  endtask

  task automatic model_step();
    bit vo;
    bit was_empty;
    vo = bus.valid_out;
    if ((streaming || waiting) && vo) n_resp++;
    if (streaming) begin
      void'(mq.pop_front());
      n_sent++;
      if (mq.size() == 0) begin
        streaming = 0; waiting = 1; silent = 0;
      end
    end else if (waiting) begin
      if (n_resp == n_sent) begin
        m_result = bus.f; m_err = 0; waiting = 0; holding = 1;
      end else if (vo) begin
        silent = 0;
      end else begin
        silent++;
        if (silent == TMO) begin
          m_result = bus.f; m_err = 1; waiting = 0; holding = 1;
        end
      end
    end else begin
      was_empty = (mq.size() == 0);
      if (bus.wr_en && mq.size() < DEPTH) mq.push_back(int'(bus.wr_data));
      if (holding) begin
        if (bus.result_ack) begin
          holding = 0; n_sent = 0; n_resp = 0;
        end
      end else if (bus.start && !was_empty) begin
        streaming = 1;
      end
    end
  endtask

  // One clock: advance model at the edge, compare just after it, return at the next negedge.
  task automatic tick();
    int exp_a;
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #2;
    cyc++;
    exp_a = streaming ? mq[0] : 0;
    chk("valid_in",     bus.valid_in, streaming);
    chk("a",            bus.a, exp_a);
    chk("count",        bus.count, mq.size());
    chk("wr_ready",     bus.wr_ready, rst_n && !streaming && !waiting && (mq.size() < DEPTH));
    chk("busy",         bus.busy, streaming || waiting);
    chk("result_valid", bus.result_valid, holding);
    chk("result",       bus.result, m_result);
    chk("err",          bus.err, holding && m_err);
    if (bus.valid_in) begin
      rec_a.push_back(int'(bus.a));
      rec_cyc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic write(input int v);
    bus.wr_en = 1'b1; bus.wr_data = A_W'(v);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic go(output int sc);
    sc = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.result_valid; i++) tick();
    chk("done_within_budget", bus.result_valid, 1);
  endtask

  task automatic ack();
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int sc;
    int base;
    int last_vi;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.start = 1'b0; bus.result_ack = 1'b0;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_valid_in", bus.valid_in, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_a", bus.a, 0);
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("wr_ready_after_release", bus.wr_ready, 1);

    // 3,4,5 -> 9,25,50
    mac_epoch++;
    write(3); write(4); write(5);
    chk("count_3", bus.count, 3);
    base = rec_a.size();
    go(sc);
    wait_done(60);
    chk("s1_nsamples", rec_a.size() - base, 3);
    chk("s1_a0", rec_a[base], 3);
    chk("s1_a1", rec_a[base+1], 4);
    chk("s1_a2", rec_a[base+2], 5);
    chk("s1_first_latency", rec_cyc[base] - sc, 1);
    chk("s1_consecutive", rec_cyc[base+2] - rec_cyc[base], 2);
    chk("s1_result", bus.result, 50);
    chk("s1_err", bus.err, 0);
    chk("s1_count", bus.count, 0);
    ack();
    chk("s1_idle_after_ack", bus.result_valid, 0);

    // Overfill: ninth write dropped
    mac_epoch++;
    for (int i = 0; i < 9; i++) write(10 + i);
    chk("full_count", bus.count, 8);
    chk("full_wr_ready", bus.wr_ready, 0);
    base = rec_a.size();
    go(sc);
    wait_done(60);
    chk("full_nsamples", rec_a.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("full_a", rec_a[base+i], 10 + i);
    chk("full_result", bus.result, 1500);
    chk("full_err", bus.err, 0);
    ack();

    // Start with empty buffer is ignored
    base = rec_a.size();
    go(sc);
    repeat (5) tick();
    chk("empty_no_valid_in", rec_a.size() - base, 0);
    chk("empty_busy", bus.busy, 0);
    chk("empty_result_valid", bus.result_valid, 0);

    // Only one MAC answer for two samples -> timeout
    mac_epoch++;
    resp_cap = 1;
    write(7); write(2);
    base = rec_a.size();
    go(sc);
    wait_done(60);
    last_vi = rec_cyc[rec_cyc.size()-1];
    chk("tmo_nsamples", rec_a.size() - base, 2);
    chk("tmo_result", bus.result, 49);
    chk("tmo_err", bus.err, 1);
    chk("tmo_cycles", cyc - last_vi, TMO + 1);
    ack();
    resp_cap = -1;

    // Hold DONE without ack, then ack together with a write
    mac_epoch++;
    write(1);
    go(sc);
    wait_done(60);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_result", bus.result, 1);
      chk("hold_result_valid", bus.result_valid, 1);
    end
    bus.result_ack = 1'b1; bus.wr_en = 1'b1; bus.wr_data = A_W'(6);
    tick();
    bus.result_ack = 1'b0; bus.wr_en = 1'b0;
    chk("ack_to_idle", bus.result_valid, 0);
    chk("ack_write_count", bus.count, 1);

    // Reset during SEND
    mac_epoch++;
    write(20); write(21); write(22); write(23);
    chk("pre_abort_count", bus.count, 5);
    base = rec_a.size();
    go(sc);
    for (int i = 0; i < 10 && (rec_a.size() - base) < 2; i++) tick();
    chk("abort_seen_two", rec_a.size() - base, 2);
    chk("abort_first_sample", rec_a[base], 6);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_valid_in", bus.valid_in, 0);
    chk("abort_count", bus.count, 0);
    chk("abort_result_valid", bus.result_valid, 0);
    chk("abort_busy", bus.busy, 0);
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("abort_wr_ready", bus.wr_ready, 1);
    repeat (3) tick();

    // Clean transfer after abort
    mac_epoch++;
    write(2);
    go(sc);
    wait_done(60);
    chk("post_result", bus.result, 4);
    chk("post_err", bus.err, 0);
    ack();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
